led_monitor: RTL and testbench

//  Receive-side checker for the 8-bit LED count bus driven by the LED stepping block.

---
 rtl/led_monitor.sv | 149 ++++++++++++++
 tb/tb_led_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_monitor.sv
// Receive-side checker for an LED count bus: expects +1 (mod 2^WIDTH) every STEP cycles,
// reports lock, error class, accepted-step count and the measured change period.
//
// state   | meaning
// IDLE    | waiting for the first bus change (its value is not judged)
// ACQUIRE | one change seen, next change must be a good step to lock
// TRACK   | locked; every change is checked, silence is a stall
// ERROR   | sticky fault, left only through CLEAR or RST
module led_monitor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 10,
  parameter int unsigned TOL   = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] LED_IN,
  input  logic             CLEAR,
  output logic             LOCKED,
  output logic             ERR,
  output logic [1:0]       ERR_CODE,
  output logic [CNT_W-1:0] INC_COUNT,
  output logic [WIDTH-1:0] LAST_VAL,
  output logic [31:0]      PERIOD
);

  localparam logic [31:0] PER_MIN  = 32'(STEP - TOL);
  localparam logic [31:0] PER_MAX  = 32'(STEP + TOL);
  localparam logic [31:0] STALL_AT = 32'(STEP + TOL + 1);

  localparam logic [1:0] CODE_NONE   = 2'd0;
  localparam logic [1:0] CODE_JUMP   = 2'd1;
  localparam logic [1:0] CODE_PERIOD = 2'd2;
  localparam logic [1:0] CODE_STALL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_TRACK,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, prev_q, last_q;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      period_q, period_d;
  logic [CNT_W-1:0] inc_q, inc_d;
  logic [1:0]       code_q, code_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] prev_inc;
  logic [CNT_W-1:0] inc_sat;
  logic             change;
  logic             step_ok;
  logic             period_ok;

  assign prev_inc  = prev_q + WIDTH'(1);
  assign change    = (cur_q != prev_q);
  assign step_ok   = (cur_q == prev_inc);
  assign period_ok = (cnt_q >= PER_MIN) && (cnt_q <= PER_MAX);
  assign inc_sat   = (&inc_q) ? inc_q : inc_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    inc_d    = inc_q;
    period_d = period_q;
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
    if (change) begin
      cnt_d    = 32'd1;
      period_d = cnt_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (change) state_d = S_ACQUIRE;
      end
      S_ACQUIRE, S_TRACK: begin
        if (change) begin
          if (!step_ok) begin
            state_d = S_ERROR;
            code_d  = CODE_JUMP;
          end else if (!period_ok) begin
            state_d = S_ERROR;
            code_d  = CODE_PERIOD;
          end else begin
            state_d = S_TRACK;
            inc_d   = inc_sat;
          end
        end else if (state_q == S_TRACK && cnt_q >= STALL_AT) begin
          state_d = S_ERROR;
          code_d  = CODE_STALL;
        end
      end
      S_ERROR: begin
        // INC_COUNT frozen; the cycle counter keeps running so PERIOD stays live
        inc_d = inc_q;
      end
      default: state_d = S_IDLE;
    endcase

    // CLEAR overrides any event seen this cycle, including the period update
    if (CLEAR) begin
      state_d  = S_IDLE;
      code_d   = CODE_NONE;
      inc_d    = '0;
      cnt_d    = 32'd0;
      period_d = period_q;
    end

    locked_d = (state_d == S_TRACK);
    err_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      prev_q   <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      inc_q    <= '0;
      code_q   <= CODE_NONE;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= LED_IN;
      prev_q   <= cur_q;
      last_q   <= cur_q;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      inc_q    <= inc_d;
      code_q   <= code_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign LOCKED    = locked_q;
  assign ERR       = err_q;
  assign ERR_CODE  = code_q;
  assign INC_COUNT = inc_q;
  assign LAST_VAL  = last_q;
  assign PERIOD    = period_q;

endmodule

// File: tb/tb_led_monitor.sv
// Bench for led_monitor: three instances (TOL=0, TOL=1, CNT_W=4); expected output values
// are queued with their due cycle when the bus is driven and compared when that cycle arrives.
module tb_led_monitor;

  localparam int DA = 0;
  localparam int DB = 8;
  localparam int DC = 16;
  localparam int F_LCK  = 0;
  localparam int F_ERR  = 1;
  localparam int F_CODE = 2;
  localparam int F_INC  = 3;
  localparam int F_LAST = 4;
  localparam int F_PER  = 5;

  logic CLK = 1'b0;
  logic RST;
  logic [7:0] led_a, led_b;
  logic clr_a, clr_b;

  logic        a_lck, a_err, b_lck, b_err, c_lck, c_err;
  logic [1:0]  a_code, b_code, c_code;
  logic [15:0] a_inc, b_inc;
  logic [3:0]  c_inc;
  logic [7:0]  a_last, b_last, c_last;
  logic [31:0] a_per, b_per, c_per;

  led_monitor #(.WIDTH(8), .STEP(10), .TOL(0), .CNT_W(16)) u_a (
    .CLK(CLK), .RST(RST), .LED_IN(led_a), .CLEAR(clr_a), .LOCKED(a_lck), .ERR(a_err),
    .ERR_CODE(a_code), .INC_COUNT(a_inc), .LAST_VAL(a_last), .PERIOD(a_per));

  led_monitor #(.WIDTH(8), .STEP(10), .TOL(1), .CNT_W(16)) u_b (
    .CLK(CLK), .RST(RST), .LED_IN(led_b), .CLEAR(clr_b), .LOCKED(b_lck), .ERR(b_err),
    .ERR_CODE(b_code), .INC_COUNT(b_inc), .LAST_VAL(b_last), .PERIOD(b_per));

  led_monitor #(.WIDTH(8), .STEP(10), .TOL(0), .CNT_W(4)) u_c (
    .CLK(CLK), .RST(RST), .LED_IN(led_a), .CLEAR(clr_a), .LOCKED(c_lck), .ERR(c_err),
    .ERR_CODE(c_code), .INC_COUNT(c_inc), .LAST_VAL(c_last), .PERIOD(c_per));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] want;
    string       tag;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(input int at, input int sel, input logic [31:0] want, input string tag);
    sb_t e;
    e.cyc  = at;
    e.sel  = sel;
    e.want = want;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] obs_of(input int sel);
    case (sel)
      DA + F_LCK:  return 32'(a_lck);
      DA + F_ERR:  return 32'(a_err);
      DA + F_CODE: return 32'(a_code);
      DA + F_INC:  return 32'(a_inc);
      DA + F_LAST: return 32'(a_last);
      DA + F_PER:  return a_per;
      DB + F_LCK:  return 32'(b_lck);
      DB + F_ERR:  return 32'(b_err);
      DB + F_CODE: return 32'(b_code);
      DB + F_INC:  return 32'(b_inc);
      DB + F_LAST: return 32'(b_last);
      DB + F_PER:  return b_per;
      DC + F_LCK:  return 32'(c_lck);
      DC + F_ERR:  return 32'(c_err);
      DC + F_CODE: return 32'(c_code);
      DC + F_INC:  return 32'(c_inc);
      DC + F_LAST: return 32'(c_last);
      DC + F_PER:  return c_per;
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge CLK) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        check(sb_q[i].tag, obs_of(sb_q[i].sel), sb_q[i].want);
        sb_q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_status(input int at, input int base, input logic lck, input logic err,
                             input logic [1:0] code, input int inc, input string tag);
    push(at, base + F_LCK,  32'(lck),  {tag, "_lck"});
    push(at, base + F_ERR,  32'(err),  {tag, "_err"});
    push(at, base + F_CODE, 32'(code), {tag, "_code"});
    push(at, base + F_INC,  32'(inc),  {tag, "_inc"});
  endtask

  task automatic pulse_clear(input int base);
    if (base == DA) clr_a = 1'b1;
    else            clr_b = 1'b1;
    push_status(cyc + 1, base, 1'b0, 1'b0, 2'd0, 0, "clear");
    tick(1);
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  initial begin
    int t0;
    RST   = 1'b1;
    led_a = 8'h00;
    led_b = 8'h00;
    clr_a = 1'b0;
    clr_b = 1'b0;
    tick(3);
    RST = 1'b0;
    push_status(cyc + 1, DA, 1'b0, 1'b0, 2'd0, 0, "rst_a");
    push(cyc + 1, DA + F_LAST, 32'd0, "rst_a_last");
    push(cyc + 1, DA + F_PER,  32'd0, "rst_a_per");
    push_status(cyc + 1, DB, 1'b0, 1'b0, 2'd0, 0, "rst_b");
    tick(4);

    // Nominal stepping at period 10 through the 0xFF -> 0x00 wrap; u_c saturates at 15
    for (int k = 1; k <= 300; k++) begin
      led_a = k[7:0];
      t0 = cyc;
      if (k == 2) push(t0 + 1, DA + F_LCK, 32'd0, "t1_prelock");
      push(t0 + 2, DA + F_LAST, 32'(k % 256), "t1_last");
      push_status(t0 + 2, DA, k >= 2, 1'b0, 2'd0, k - 1, "t1");
      if (k >= 2) push(t0 + 2, DA + F_PER, 32'd10, "t1_per");
      push(t0 + 2, DC + F_INC, 32'((k - 1 > 15) ? 15 : k - 1), "t6_inc");
      push(t0 + 2, DC + F_ERR, 32'd0, "t6_err");
      tick(10);
    end

    // Relock, then a value jump 0x05 -> 0x07
    pulse_clear(DA);
    push(cyc, DA + F_PER, 32'd10, "clear_per_kept");
    tick(2);
    led_a = 8'h04;
    tick(10);
    led_a = 8'h05;
    push_status(cyc + 2, DA, 1'b1, 1'b0, 2'd0, 1, "t2_lock");
    tick(10);
    led_a = 8'h07;
    t0 = cyc;
    push(t0 + 1, DA + F_LCK, 32'd1, "t2_pre_lck");
    push(t0 + 1, DA + F_ERR, 32'd0, "t2_pre_err");
    push_status(t0 + 2, DA, 1'b0, 1'b1, 2'd1, 1, "t2_jump");
    push(t0 + 2, DA + F_LAST, 32'h07, "t2_last");
    push_status(t0 + 102, DA, 1'b0, 1'b1, 2'd1, 1, "t2_sticky");
    tick(105);

    // CLEAR out of ERROR, relock
    pulse_clear(DA);
    tick(2);
    led_a = 8'h10;
    tick(10);
    led_a = 8'h11;
    push_status(cyc + 2, DA, 1'b1, 1'b0, 2'd0, 1, "t5_relock");
    tick(10);
    led_a = 8'h12;
    push(cyc + 2, DA + F_INC, 32'd2, "t5_inc2");
    tick(9);

    // Short period (would be code 2) processed on the same edge as CLEAR
    led_a = 8'h13;
    t0 = cyc;
    tick(1);
    clr_a = 1'b1;
    push_status(t0 + 2, DA, 1'b0, 1'b0, 2'd0, 0, "t5_clrwin");
    push(t0 + 2, DA + F_PER, 32'd10, "t5_clrwin_per");
    push(t0 + 2, DA + F_LAST, 32'h13, "t5_clrwin_last");
    tick(1);
    clr_a = 1'b0;
    tick(8);
    led_a = 8'h14;
    push(cyc + 2, DA + F_LCK, 32'd0, "t5_idle_first");
    tick(10);
    led_a = 8'h15;
    push_status(cyc + 2, DA, 1'b1, 1'b0, 2'd0, 1, "t5_relock2");
    push(cyc + 2, DA + F_PER, 32'd10, "t5_relock2_per");
    tick(4);

    // RST while tracking
    RST = 1'b1;
    push_status(cyc + 1, DA, 1'b0, 1'b0, 2'd0, 0, "t5_rst");
    push(cyc + 1, DA + F_LAST, 32'd0, "t5_rst_last");
    push(cyc + 1, DA + F_PER,  32'd0, "t5_rst_per");
    tick(1);
    RST = 1'b0;
    tick(3);

    // TOL=1: periods 9 and 11 accepted, 12 rejected even on the stall boundary cycle
    led_b = 8'h01;
    tick(10);
    led_b = 8'h02;
    push_status(cyc + 2, DB, 1'b1, 1'b0, 2'd0, 1, "t3_lock");
    push(cyc + 2, DB + F_PER, 32'd10, "t3_per10");
    tick(9);
    led_b = 8'h03;
    push_status(cyc + 2, DB, 1'b1, 1'b0, 2'd0, 2, "t3_p9");
    push(cyc + 2, DB + F_PER, 32'd9, "t3_per9");
    tick(11);
    led_b = 8'h04;
    push_status(cyc + 2, DB, 1'b1, 1'b0, 2'd0, 3, "t3_p11");
    push(cyc + 2, DB + F_PER, 32'd11, "t3_per11");
    tick(10);
    led_b = 8'h05;
    push(cyc + 2, DB + F_INC, 32'd4, "t3_inc4");
    tick(12);
    led_b = 8'h06;
    t0 = cyc;
    push(t0 + 1, DB + F_LCK, 32'd1, "t3_pre_lck");
    push(t0 + 1, DB + F_ERR, 32'd0, "t3_pre_err");
    push_status(t0 + 2, DB, 1'b0, 1'b1, 2'd2, 4, "t3_p12");
    push(t0 + 2, DB + F_PER, 32'd12, "t3_per12");
    tick(5);

    // Stall: bus held after lock
    pulse_clear(DB);
    tick(2);
    led_b = 8'h20;
    tick(10);
    led_b = 8'h21;
    t0 = cyc;
    push(t0 + 2, DB + F_LCK, 32'd1, "t4_lock");
    push(t0 + 13, DB + F_LCK, 32'd1, "t4_prestall_lck");
    push(t0 + 13, DB + F_ERR, 32'd0, "t4_prestall_err");
    push_status(t0 + 14, DB, 1'b0, 1'b1, 2'd3, 1, "t4_stall");
    tick(20);

    // Jump with a bad period on the stall cycle: value jump takes priority
    pulse_clear(DB);
    tick(2);
    led_b = 8'h30;
    tick(10);
    led_b = 8'h31;
    push(cyc + 2, DB + F_LCK, 32'd1, "t4b_lock");
    tick(12);
    led_b = 8'h33;
    push_status(cyc + 2, DB, 1'b0, 1'b1, 2'd1, 1, "t4b_prio");
    tick(8);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
